// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types, default widths and bubble constants for the
//               handshaked pipeline stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 16;
  localparam int PIPE_CNT_W  = 32;

  // Occupancy: EMPTY = no entry, FULL = main only, SKID = main and skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } idex_data_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
    logic [4:0] rd;
  } idex_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] mem_size;
    logic [4:0] rd;
    logic [3:0] rsvd;
  } exmem_ctrl_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [8:0]  rsvd;
  } memwb_ctrl_t;

  // All-zero control words leave register file and memory untouched.
  localparam idex_ctrl_t  IDEX_CTRL_BUBBLE  = '0;
  localparam exmem_ctrl_t EXMEM_CTRL_BUBBLE = '0;
  localparam memwb_ctrl_t MEMWB_CTRL_BUBBLE = '0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_cnt
// Description : Saturating event counter with enable; clears only on rst.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_cnt
  import pipe_pkg::*;
#(
  parameter int W = PIPE_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule : pipe_perf_cnt
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Handshaked pipeline stage register with 2-entry skid buffer,
//               stall, flush and bubble injection. Optional performance
//               counters are built when PIPE_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = PIPE_DATA_W,
  parameter int                CTRL_W      = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int                CNT_W       = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Valid bits of main and skid are carried by the occupancy state.
  pipe_state_e       r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic w_in_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_emit;

  // in_ready depends only on local state, never on out_ready.
  assign w_in_ready  = (r_state != SKID) && !stall;
  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = in_valid && w_in_ready;
  assign w_emit      = w_out_valid && out_ready && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else if (!stall) begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_state     <= FULL;
          end
        end
        FULL: begin
          if (w_accept && w_emit) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_accept) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_state     <= SKID;
          end else if (w_emit) begin
            r_state <= EMPTY;
          end
        end
        SKID: begin
          if (w_emit) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_state     <= FULL;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_main_data : '0;
  assign out_ctrl  = w_out_valid ? r_main_ctrl : BUBBLE_CTRL;

`ifdef PIPE_PERF_CNT_EN
  logic w_stall_cnt_en;
  logic w_flush_cnt_en;

  assign w_stall_cnt_en = stall && !flush && (r_state != EMPTY);
  assign w_flush_cnt_en = flush && (r_state != EMPTY);

  pipe_perf_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_stall_cnt_en),
    .o_cnt (stall_cnt)
  );

  pipe_perf_cnt #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_flush_cnt_en),
    .o_cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule : pipe_stage_reg
`default_nettype wire
